// File: rtl/fp_addsub_driver_pkg.sv
// Shared types and constants for the FP add/sub driver.
package fp_addsub_pkg;

  localparam int unsigned FP_W = 32;

  typedef logic [FP_W-1:0] fp32_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam fp32_t FP_ONE = 32'h3F80_0000;
  localparam fp32_t FP_TWO = 32'h4000_0000;

  // One buffered result: the op that produced it and the adder word.
  typedef struct packed {
    logic  op;
    fp32_t result;
  } res_t;

endpackage

// File: rtl/fp_addsub_driver_if.sv
// Operand stream, adder issue port and result stream of the driver.
interface fp_addsub_if;
  import fp_addsub_pkg::*;

  logic  in_valid;
  logic  in_ready;
  logic  in_op;
  fp32_t in_a;
  fp32_t in_b;

  logic  load;
  logic  op;
  fp32_t numar1;
  fp32_t numar2;
  fp32_t numar;

  logic  out_valid;
  logic  out_ready;
  fp32_t out_result;
  logic  out_op;

  // Driver side.
  modport slave (
    input  in_valid, in_op, in_a, in_b, numar, out_ready,
    output in_ready, load, op, numar1, numar2, out_valid, out_result, out_op
  );

  // Environment side: operand producer, adder and result consumer.
  modport master (
    output in_valid, in_op, in_a, in_b, numar, out_ready,
    input  in_ready, load, op, numar1, numar2, out_valid, out_result, out_op
  );

endinterface

// File: rtl/fp_addsub_driver_fifo.sv
// Small synchronous FIFO holding {op, result} until the consumer takes it.
module fp_result_fifo
  import fp_addsub_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push_i,
  input  res_t                           push_data_i,
  input  logic                           pop_i,
  output res_t                           head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  res_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_c, do_pop_c;

  // Pointer and occupancy update; a push while full is only taken alongside a pop.
  always_comb begin
    do_pop_c  = pop_i && (count_q != '0);
    do_push_c = push_i && ((count_q != CW'(DEPTH)) || do_pop_c);
    wr_ptr_d  = wr_ptr_q + AW'(do_push_c);
    rd_ptr_d  = rd_ptr_q + AW'(do_pop_c);
    count_d   = count_q + CW'(do_push_c) - CW'(do_pop_c);
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fp_addsub_driver.sv
// Sequencer that issues operand pairs to the pipelined FP adder and returns results in order.
module fp_addsub_driver
  import fp_addsub_pkg::*;
#(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 4
) (
  input logic        clk,
  input logic        reset,
  fp_addsub_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(LATENCY + 1);
  localparam int unsigned SW = $clog2(DEPTH + LATENCY + 2);

  logic               load_q, load_d;
  logic               op_q, op_d;
  fp32_t              a_q, a_d;
  fp32_t              b_q, b_d;
  logic [LATENCY-1:0] tag_v_q, tag_v_d;
  logic [LATENCY-1:0] tag_op_q, tag_op_d;
  logic [IW-1:0]      inflight_c;
  logic [CW-1:0]      count;
  logic               in_ready_c, accept_c, pop_c;
  res_t               push_data, head;

  // Credits: every issued or in-flight op already owns a buffer slot.
  always_comb begin
    inflight_c = '0;
    for (int i = 0; i < int'(LATENCY); i++) inflight_c = inflight_c + IW'(tag_v_q[i]);
    in_ready_c = (SW'(count) + SW'(inflight_c) + SW'(load_q)) < SW'(DEPTH);
    accept_c   = bus.in_valid && in_ready_c;
  end

  // Operand register next state and tag pipe shift.
  always_comb begin
    load_d      = accept_c;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_v_d     = '0;
    tag_op_d    = '0;
    if (accept_c) begin
      op_d = bus.in_op;
      a_d  = bus.in_a;
      b_d  = bus.in_b;
    end
    tag_v_d[0]  = load_q;
    tag_op_d[0] = op_q;
    for (int i = 1; i < int'(LATENCY); i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_op_d[i] = tag_op_q[i-1];
    end
  end

  // Issue and tag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q   <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      tag_v_q  <= '0;
      tag_op_q <= '0;
    end else begin
      load_q   <= load_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tag_v_q  <= tag_v_d;
      tag_op_q <= tag_op_d;
    end
  end

  // Result capture when a valid tag leaves the pipe.
  always_comb begin
    push_data        = '0;
    push_data.op     = tag_op_q[LATENCY-1];
    push_data.result = bus.numar;
    pop_c            = (count != '0) && bus.out_ready;
  end

  fp_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (tag_v_q[LATENCY-1]),
    .push_data_i (push_data),
    .pop_i       (pop_c),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.in_ready   = in_ready_c;
  assign bus.load       = load_q;
  assign bus.op         = op_q;
  assign bus.numar1     = a_q;
  assign bus.numar2     = b_q;
  assign bus.out_valid  = (count != '0);
  assign bus.out_result = head.result;
  assign bus.out_op     = head.op;

endmodule

// File: tb/tb_fp_addsub_driver.sv
// Directed bench: two driver builds (3/4 and 1/2) against a behavioural pipelined adder.
module tb_fp_addsub_driver;
  import fp_addsub_pkg::*;

  localparam int unsigned LA = 3;
  localparam int unsigned DA = 4;
  localparam int unsigned LB = 1;
  localparam int unsigned DB = 2;
  localparam int NV = 6;

  typedef struct {
    logic  op;
    fp32_t a;
    fp32_t b;
    fp32_t exp;
  } vec_t;

  vec_t vt [NV];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_addsub_if ifa ();
  fp_addsub_if ifb ();

  fp_addsub_driver #(.LATENCY(LA), .DEPTH(DA)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
  fp_addsub_driver #(.LATENCY(LB), .DEPTH(DB)) dut_b (.clk(clk), .reset(rst), .bus(ifb));

  logic  in_valid [2];
  logic  in_op    [2];
  fp32_t in_a     [2];
  fp32_t in_b     [2];
  logic  out_ready[2];

  logic  ready_w [2];
  logic  load_w  [2];
  logic  op_w    [2];
  fp32_t n1_w    [2];
  fp32_t n2_w    [2];
  logic  ov_w    [2];
  fp32_t ores_w  [2];
  logic  oop_w   [2];

  fp32_t pa [8];
  fp32_t pb [8];

  assign ifa.in_valid = in_valid[0];  assign ifb.in_valid = in_valid[1];
  assign ifa.in_op = in_op[0];        assign ifb.in_op = in_op[1];
  assign ifa.in_a = in_a[0];          assign ifb.in_a = in_a[1];
  assign ifa.in_b = in_b[0];          assign ifb.in_b = in_b[1];
  assign ifa.out_ready = out_ready[0]; assign ifb.out_ready = out_ready[1];
  assign ifa.numar = pa[LA-1];        assign ifb.numar = pb[LB-1];

  assign ready_w[0] = ifa.in_ready;   assign ready_w[1] = ifb.in_ready;
  assign load_w[0] = ifa.load;        assign load_w[1] = ifb.load;
  assign op_w[0] = ifa.op;            assign op_w[1] = ifb.op;
  assign n1_w[0] = ifa.numar1;        assign n1_w[1] = ifb.numar1;
  assign n2_w[0] = ifa.numar2;        assign n2_w[1] = ifb.numar2;
  assign ov_w[0] = ifa.out_valid;     assign ov_w[1] = ifb.out_valid;
  assign ores_w[0] = ifa.out_result;  assign ores_w[1] = ifb.out_result;
  assign oop_w[0] = ifa.out_op;       assign oop_w[1] = ifb.out_op;

  int checks = 0;
  int errors = 0;
  int acc_cnt [2];
  int pop_cnt [2];
  int load_cnt[2];
  bit acc_flag[2];
  int si      [2];
  logic [32:0] sbq0 [$];
  logic [32:0] sbq1 [$];

  // Adder model: known vectors return their real sums, anything else a fixed scramble.
  function automatic fp32_t model(input logic op, input fp32_t a, input fp32_t b);
    for (int i = 0; i < NV; i++)
      if (vt[i].op === op && vt[i].a === a && vt[i].b === b) return vt[i].exp;
    return a ^ {b[15:0], b[31:16]} ^ {31'd0, op};
  endfunction

  // Adder pipes: value sampled with load appears on numar LATENCY edges later.
  always @(posedge clk) begin
    pa[0] <= model(ifa.op, ifa.numar1, ifa.numar2);
    pb[0] <= model(ifb.op, ifb.numar1, ifb.numar2);
    for (int i = 1; i < 8; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end

  function automatic fp32_t gen_a(input int i);
    return 32'h3F80_0000 + (32'(i) << 16);
  endfunction

  function automatic fp32_t gen_b(input int i);
    return 32'h4000_0000 + (32'(i) << 12) + 32'd7;
  endfunction

  function automatic int qsz(input int d);
    return (d == 0) ? sbq0.size() : sbq1.size();
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sampled mid-cycle: records accepts and pops that the next rising edge will perform.
  task automatic monitor();
    logic [32:0] e;
    for (int d = 0; d < 2; d++) begin
      acc_flag[d] = 1'b0;
      if (!rst) begin
        if (load_w[d]) load_cnt[d]++;
        if (in_valid[d] && ready_w[d]) begin
          acc_flag[d] = 1'b1;
          acc_cnt[d]++;
          e = {in_op[d], model(in_op[d], in_a[d], in_b[d])};
          if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
        end
        if (ov_w[d] && out_ready[d]) begin
          pop_cnt[d]++;
          if (qsz(d) == 0) check($sformatf("unexpected_result_d%0d", d), 64'(ores_w[d]), 64'hX);
          else begin
            e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
            check($sformatf("result_order_d%0d", d), 64'({oop_w[d], ores_w[d]}), 64'(e));
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int d, input int maxc);
    int n = 0;
    out_ready[d] = 1'b1;
    while ((ov_w[d] || qsz(d) != 0) && n < maxc) begin cyc(); n++; end
    if (n >= maxc) check($sformatf("drain_timeout_d%0d", d), 64'(n), 64'(maxc - 1));
  endtask

  // One isolated operation: checks accept-to-out_valid latency and the head entry.
  task automatic single(input int d, input int idx, input int lat_exp);
    bit ok = 1'b0;
    int lat = 0;
    out_ready[d] = 1'b0;
    in_valid[d] = 1'b1; in_op[d] = vt[idx].op; in_a[d] = vt[idx].a; in_b[d] = vt[idx].b;
    for (int n = 0; n < 20 && !ok; n++) begin cyc(); ok = acc_flag[d]; end
    in_valid[d] = 1'b0;
    check($sformatf("accept_d%0d_v%0d", d, idx), 64'(ok), 64'd1);
    while (!ov_w[d] && lat < 20) begin cyc(); lat++; end
    check($sformatf("latency_d%0d_v%0d", d, idx), 64'(lat), 64'(lat_exp));
    check($sformatf("out_result_d%0d_v%0d", d, idx), 64'(ores_w[d]), 64'(vt[idx].exp));
    check($sformatf("out_op_d%0d_v%0d", d, idx), 64'(oop_w[d]), 64'(vt[idx].op));
    out_ready[d] = 1'b1;
    cyc();
    out_ready[d] = 1'b0;
    check($sformatf("emptied_d%0d_v%0d", d, idx), 64'(ov_w[d]), 64'd0);
  endtask

  // Offer pairs si..n-1 with continuous in_valid for at most maxc cycles.
  task automatic stream(input int d, input int n, input int maxc, output int used);
    used = 0;
    while (si[d] < n && used < maxc) begin
      in_valid[d] = 1'b1;
      in_op[d] = 1'(si[d]);
      in_a[d] = gen_a(si[d]);
      in_b[d] = gen_b(si[d]);
      cyc();
      used++;
      if (acc_flag[d]) si[d]++;
    end
    in_valid[d] = 1'b0;
  endtask

  // Consumer stalled: exactly DEPTH accepts, then release and collect all six in order.
  task automatic stall(input int d, input int depth);
    int used, a0, l0, p0;
    out_ready[d] = 1'b0;
    si[d] = 0;
    a0 = acc_cnt[d]; l0 = load_cnt[d]; p0 = pop_cnt[d];
    stream(d, 6, 15, used);
    check($sformatf("stall_accepts_d%0d", d), 64'(acc_cnt[d] - a0), 64'(depth));
    check($sformatf("stall_loads_d%0d", d), 64'(load_cnt[d] - l0), 64'(depth));
    check($sformatf("stall_in_ready_d%0d", d), 64'(ready_w[d]), 64'd0);
    check($sformatf("stall_out_valid_d%0d", d), 64'(ov_w[d]), 64'd1);
    out_ready[d] = 1'b1;
    stream(d, 6, 80, used);
    drain(d, 40);
    check($sformatf("stall_total_acc_d%0d", d), 64'(acc_cnt[d] - a0), 64'd6);
    check($sformatf("stall_total_pop_d%0d", d), 64'(pop_cnt[d] - p0), 64'd6);
    out_ready[d] = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag, input int d);
    check($sformatf("%s_load_d%0d", tag, d), 64'(load_w[d]), 64'd0);
    check($sformatf("%s_op_d%0d", tag, d), 64'(op_w[d]), 64'd0);
    check($sformatf("%s_numar1_d%0d", tag, d), 64'(n1_w[d]), 64'd0);
    check($sformatf("%s_numar2_d%0d", tag, d), 64'(n2_w[d]), 64'd0);
    check($sformatf("%s_out_valid_d%0d", tag, d), 64'(ov_w[d]), 64'd0);
    check($sformatf("%s_out_result_d%0d", tag, d), 64'(ores_w[d]), 64'd0);
    check($sformatf("%s_out_op_d%0d", tag, d), 64'(oop_w[d]), 64'd0);
  endtask

  initial begin
    int used, a0, p0, c0;
    bit b0, b1;

    vt[0] = '{OP_ADD, FP_ONE, FP_TWO, 32'h4040_0000};
    vt[1] = '{OP_SUB, 32'h4080_0000, 32'h40A0_0000, 32'hBF80_0000};
    vt[2] = '{OP_ADD, 32'h4080_0000, 32'h40A0_0000, 32'h4110_0000};
    vt[3] = '{OP_ADD, FP_ONE, FP_ONE, FP_TWO};
    vt[4] = '{OP_SUB, 32'h4040_0000, FP_ONE, FP_TWO};
    vt[5] = '{OP_ADD, FP_TWO, FP_TWO, 32'h4080_0000};

    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_op[d] = 1'b0; in_a[d] = '0; in_b[d] = '0; out_ready[d] = 1'b0;
      acc_cnt[d] = 0; pop_cnt[d] = 0; load_cnt[d] = 0; acc_flag[d] = 1'b0; si[d] = 0;
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_reset_vals("por", d);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("in_ready_after_reset_d%0d", d), 64'(ready_w[d]), 64'd1);

    for (int i = 0; i < NV; i++) single(0, i, int'(LA) + 1);

    // Back-to-back subtract then add.
    in_valid[0] = 1'b1; in_op[0] = vt[1].op; in_a[0] = vt[1].a; in_b[0] = vt[1].b;
    cyc(); b0 = acc_flag[0];
    in_op[0] = vt[2].op; in_a[0] = vt[2].a; in_b[0] = vt[2].b;
    cyc(); b1 = acc_flag[0];
    in_valid[0] = 1'b0;
    check("b2b_accepts", 64'({b0, b1}), 64'b11);
    p0 = pop_cnt[0];
    drain(0, 20);
    check("b2b_pops", 64'(pop_cnt[0] - p0), 64'd2);
    out_ready[0] = 1'b0;

    stall(0, int'(DA));

    // Sustained streaming with a free-running consumer.
    si[0] = 0; a0 = acc_cnt[0]; p0 = pop_cnt[0];
    out_ready[0] = 1'b1;
    stream(0, 100, 1000, used);
    drain(0, 40);
    check("sustain_accepts", 64'(acc_cnt[0] - a0), 64'd100);
    check("sustain_pops", 64'(pop_cnt[0] - p0), 64'd100);
    check("sustain_rate", 64'(used <= 100 * int'(LA + 3) / int'(DA) + 4 * int'(LA + 3)), 64'd1);
    out_ready[0] = 1'b0;

    // Reset with two results buffered and two ops in flight.
    si[0] = 0;
    stream(0, 2, 10, used);
    repeat (LA + 2) cyc();
    check("pre_reset_buffered", 64'(ov_w[0]), 64'd1);
    stream(0, 4, 2, used);
    check("pre_reset_issued", 64'(si[0]), 64'd4);
    rst = 1'b1;
    #1;
    check_reset_vals("midop", 0);
    sbq0.delete();
    sbq1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", 64'(ready_w[0]), 64'd1);
    c0 = pop_cnt[0];
    out_ready[0] = 1'b1;
    repeat (LA + 3) cyc();
    check("no_stale_result", 64'(pop_cnt[0] - c0), 64'd0);
    single(0, 3, int'(LA) + 1);

    single(1, 0, int'(LB) + 1);
    stall(1, int'(DB));

    for (int d = 0; d < 2; d++) check($sformatf("scoreboard_empty_d%0d", d), 64'(qsz(d)), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d errors", errors);
    $fatal(1, "watchdog");
  end

endmodule
